// File: rtl/ps2_key_tracker.sv
// PS/2 scancode tracker: prefix-aware parser (E0/F0), held-key bitmap for a configurable
// key table, and a first-word fall-through FIFO of make/break events.
module ps2_key_tracker #(
  parameter int unsigned NUM_KEYS = 8,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES =
    {9'h02B, 9'h023, 9'h015, 9'h01C, 9'h174, 9'h172, 9'h16B, 9'h175},
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit FILTER_REPEAT = 1'b1,
  localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          key_data,
  input  logic                key_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                ev_valid,
  output logic [IDX_W:0]      ev_data,
  input  logic                ev_ready,
  output logic [CNT_W-1:0]    ev_count,
  output logic                overflow,
  output logic [8:0]          last_code
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e state_q, state_d;

  logic       code_done;
  logic       code_ext;
  logic       code_make;
  logic [8:0] code;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             held_was;

  logic [NUM_KEYS-1:0] key_held_q;
  logic [8:0]          last_code_q;
  logic                overflow_q;

  logic [IDX_W:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  logic ev_push;
  logic ev_pop;
  logic fifo_full;
  logic wr_en;

  // Parser: prefixes only move state; any other byte completes a code.
  always_comb begin
    state_d   = state_q;
    code_done = 1'b0;
    code_ext  = 1'b0;
    code_make = 1'b1;
    if (key_valid) begin
      unique case (state_q)
        StIdle: begin
          if (key_data == 8'hE0) begin
            state_d = StExt;
          end else if (key_data == 8'hF0) begin
            state_d = StBrk;
          end else begin
            code_done = 1'b1;
          end
        end
        StExt: begin
          if (key_data == 8'hF0) begin
            state_d = StExtBrk;
          end else if (key_data == 8'hE0) begin
            state_d = StExt;
          end else begin
            code_done = 1'b1;
            code_ext  = 1'b1;
            state_d   = StIdle;
          end
        end
        StBrk: begin
          code_done = 1'b1;
          code_make = 1'b0;
          state_d   = StIdle;
        end
        StExtBrk: begin
          code_done = 1'b1;
          code_ext  = 1'b1;
          code_make = 1'b0;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign code = {code_ext, key_data};

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == code) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign held_was  = key_held_q[hit_idx];
  assign ev_push   = code_done && hit && (!FILTER_REPEAT || (held_was != code_make));
  assign ev_pop    = ev_valid && ev_ready;
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en     = ev_push && (!fifo_full || ev_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_held_q  <= '0;
      last_code_q <= '0;
    end else if (code_done) begin
      last_code_q <= code;
      if (hit) begin
        key_held_q[hit_idx] <= code_make;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= {code_make, hit_idx};
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (ev_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (wr_en && !ev_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en && ev_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (ev_push && !wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign key_held  = key_held_q;
  assign ev_valid  = (count_q != '0);
  assign ev_data   = mem_q[rptr_q];
  assign ev_count  = count_q;
  assign overflow  = overflow_q;
  assign last_code = last_code_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker; a byte-level reference model
// predicts held keys, last code, overflow and the event queue.
module tb_ps2_key_tracker;

  localparam int Depth = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] key_data = 8'h00;
  logic       key_valid = 1'b0;
  logic       ev_ready = 1'b0;

  logic [7:0] key_held;
  logic       ev_valid;
  logic [3:0] ev_data;
  logic [3:0] ev_count;
  logic       overflow;
  logic [8:0] last_code;

  logic [7:0] nf_key_held;
  logic       nf_ev_valid;
  logic [3:0] nf_ev_data;
  logic [3:0] nf_ev_count;
  logic       nf_overflow;
  logic [8:0] nf_last_code;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ps2_key_tracker dut (
    .clock     (clock),
    .reset     (reset),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_held  (key_held),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .last_code (last_code)
  );

  ps2_key_tracker #(.FILTER_REPEAT(1'b0)) dut_nf (
    .clock     (clock),
    .reset     (reset),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_held  (nf_key_held),
    .ev_valid  (nf_ev_valid),
    .ev_data   (nf_ev_data),
    .ev_ready  (1'b0),
    .ev_count  (nf_ev_count),
    .overflow  (nf_overflow),
    .last_code (nf_last_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (key table order: up, left, down, right, 1C, 15, 23, 2B).
  logic [8:0] ktab [8] = '{9'h175, 9'h16B, 9'h172, 9'h174, 9'h01C, 9'h015, 9'h023, 9'h02B};
  bit         m_ext, m_brk, m_ovf, m_head_zero, armed;
  logic [7:0] m_held;
  logic [8:0] m_last;
  logic [3:0] exp_q [$];

  task automatic model_byte(input logic [7:0] b, input bit popped, input bit was_full);
    logic [8:0] c;
    bit         make;
    int         idx;
    if (!m_brk && b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (!m_brk && b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      c      = {m_ext, b};
      make   = !m_brk;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_last = c;
      idx    = -1;
      for (int i = 7; i >= 0; i--) if (ktab[i] == c) idx = i;
      if (idx >= 0) begin
        if (m_held[idx] != make) begin
          if (was_full && !popped) m_ovf = 1'b1;
          else begin
            exp_q.push_back({make, 3'(idx)});
            m_head_zero = 1'b0;
          end
        end
        m_held[idx] = make;
      end
    end
  endtask

  // Monitor/scoreboard: checks DUT against model, then advances model for the coming edge.
  always @(negedge clock) begin
    int  n;
    bit  pop, full;
    n = exp_q.size();
    if (armed) begin
      chk("ev_count", 32'(ev_count), 32'(n));
      chk("ev_valid", 32'(ev_valid), 32'(n != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("last_code", 32'(last_code), 32'(m_last));
      if (n != 0) chk("ev_head", 32'(ev_data), 32'(exp_q[0]));
      else if (m_head_zero) chk("ev_data_reset", 32'(ev_data), 32'd0);
    end
    if (reset) begin
      m_ext = 0; m_brk = 0; m_ovf = 0; m_head_zero = 1;
      m_held = '0; m_last = '0;
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      pop  = (n != 0) && ev_ready;
      full = (n == Depth);
      if (pop) void'(exp_q.pop_front());
      if (key_valid) model_byte(key_data, pop, full);
    end
  end

  task automatic step(input bit v, input logic [7:0] b, input bit r, input bit rs);
    key_valid = v;
    key_data  = b;
    ev_ready  = r;
    reset     = rs;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit r);
    step(1'b1, b, r, 1'b0);
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, r, 1'b0);
  endtask

  task automatic fill_round(input logic [7:0] low [8], input bit ext [8]);
    for (int k = 0; k < 8; k++) begin
      if (ext[k]) send(8'hE0, 1'b0);
      send(low[k], 1'b0);
    end
  endtask

  logic [7:0] lows [8] = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h1C, 8'h15, 8'h23, 8'h2B};
  bit         exts [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int         ready_pct;
    int         sel;
    logic [7:0] b;
    @(posedge clock);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Extended make then extended break of key 0.
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Repeat filtering versus unfiltered instance.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    chk("nf_ev_count", 32'(nf_ev_count), 32'd4);
    chk("nf_key_held", 32'(nf_key_held), 32'd0);
    idle(4, 1'b1);

    // Unmatched break, then lone break of an unheld key.
    send(8'hF0, 1'b0); send(8'h5A, 1'b0);
    send(8'hF0, 1'b0); send(8'h2B, 1'b0);
    idle(2, 1'b0);

    // Two fill/drain rounds with overflow and push-on-pop while full.
    for (int round = 0; round < 2; round++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      fill_round(lows, exts);
      send(8'hF0, 1'b0); send(8'h1C, 1'b0);
      idle(2, 1'b0);
      send(8'hF0, 1'b0); send(8'h15, 1'b1);
      idle(12, 1'b1);
      fill_round(lows, exts);
      idle(12, 1'b1);
    end

    // Reset mid-sequence discards the pending E0.
    send(8'hE0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    send(8'h75, 1'b0);
    idle(2, 1'b0);

    // Random traffic biased toward prefixes and table codes.
    ready_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) ready_pct = int'($urandom_range(0, 100));
      sel = int'($urandom_range(0, 9));
      if (sel < 2) b = 8'hE0;
      else if (sel < 4) b = 8'hF0;
      else if (sel < 8) b = lows[$urandom_range(0, 7)];
      else if (sel == 8) b = 8'($urandom_range(0, 255));
      else b = 8'hE1;
      step($urandom_range(0, 4) != 0, b, int'($urandom_range(0, 99)) < ready_pct,
           $urandom_range(0, 399) == 0);
    end
    idle(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
